// File: rtl/nq_pkg.sv
// rtl/nq_pkg.sv - NanoQuarter shared constants: ALU codes, operand-B selects, flush depth.
package nq_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] OPB_REG  = 2'b00;
  localparam logic [1:0] OPB_SEXT = 2'b01;
  localparam logic [1:0] OPB_ZEXT = 2'b10;

  localparam int FLUSH_SLOTS_DEFAULT = 1;

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/nq_execute_stage_if.sv
// rtl/nq_execute_stage_if.sv - decode-to-execute inputs and execute-to-memory/PC-mux outputs.
interface nq_execute_stage_if;
  logic        valid;
  logic [15:0] reg1data;
  logic [15:0] reg2data;
  logic [2:0]  ALU_func;
  logic [1:0]  shamt;
  logic [6:0]  iVal;
  logic [2:0]  rd;
  logic [31:0] pc;
  logic        jmp;
  logic        jr;
  logic        bne;
  logic        memRead;
  logic        memWrite;
  logic        mem_stall;
  logic        in_ready;
  logic        ex_valid;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [2:0]  ex_rd;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_regWrite;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    input  valid, reg1data, reg2data, ALU_func, shamt, iVal, rd, pc,
           jmp, jr, bne, memRead, memWrite, mem_stall,
    output in_ready, ex_valid, alu_result, store_data, ex_rd,
           ex_memRead, ex_memWrite, ex_regWrite, redirect, redirect_pc
  );

  modport master (
    output valid, reg1data, reg2data, ALU_func, shamt, iVal, rd, pc,
           jmp, jr, bne, memRead, memWrite, mem_stall,
    input  in_ready, ex_valid, alu_result, store_data, ex_rd,
           ex_memRead, ex_memWrite, ex_regWrite, redirect, redirect_pc
  );
endinterface

// File: rtl/nq_alu.sv
// rtl/nq_alu.sv - combinational 16-bit ALU, modulo arithmetic, shifts by b[3:0].
module nq_alu
  import nq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  func,
  output logic [15:0] result
);

  always_comb begin
    result = a + b;
    case (func)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      ALU_SLT: result = {15'd0, $signed(a) < $signed(b)};
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/nq_execute_stage.sv
// rtl/nq_execute_stage.sv - NanoQuarter execute stage: ALU, bne/jmp resolution, redirect and wrong-path squash.
module nq_execute_stage
  import nq_pkg::*;
#(
  parameter int FLUSH_SLOTS = FLUSH_SLOTS_DEFAULT
)
(
  input logic               clk,
  input logic               rst,
  nq_execute_stage_if.slave bus
);

  logic [15:0] op_b;
  logic [15:0] alu_out;
  logic [2:0]  func;
  logic [1:0]  sq_cnt;
  logic        accept;
  logic        squashed;
  logic        live;
  logic        taken;
  logic [31:0] rel_target;
  logic [31:0] target;

  assign bus.in_ready = ~bus.mem_stall;
  assign accept       = bus.valid & ~bus.mem_stall;
  assign squashed     = (sq_cnt != 2'd0);
  assign live         = accept & ~squashed;

  always_comb begin
    case (bus.shamt)
      OPB_SEXT: op_b = sext7(bus.iVal);
      OPB_ZEXT: op_b = {9'd0, bus.iVal};
      default:  op_b = bus.reg2data;
    endcase
  end

  // Memory ops always compute the address, whatever code decode supplied.
  assign func = (bus.memRead | bus.memWrite) ? ALU_ADD : bus.ALU_func;

  nq_alu u_alu (
    .a      (bus.reg1data),
    .b      (op_b),
    .func   (func),
    .result (alu_out)
  );

  // Branch compare uses the raw register operand, never the immediate.
  assign taken      = bus.jmp | (bus.bne & (bus.reg1data != bus.reg2data));
  assign rel_target = bus.pc + 32'd1 + {{25{bus.iVal[6]}}, bus.iVal};
  assign target     = (bus.jmp & bus.jr) ? {16'd0, bus.reg1data} : rel_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_regWrite <= 1'b0;
      bus.ex_memRead  <= 1'b0;
      bus.ex_memWrite <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.alu_result  <= 16'd0;
      bus.store_data  <= 16'd0;
      bus.redirect_pc <= 32'd0;
      bus.ex_rd       <= 3'd0;
      sq_cnt          <= 2'd0;
    end else if (bus.mem_stall) begin
      bus.redirect <= 1'b0;
    end else begin
      bus.ex_valid    <= live;
      bus.ex_regWrite <= live & ~bus.memWrite & ~bus.bne & ~bus.jmp;
      bus.ex_memRead  <= live & bus.memRead;
      bus.ex_memWrite <= live & bus.memWrite;
      bus.redirect    <= live & taken;
      if (live) begin
        bus.alu_result <= alu_out;
        bus.store_data <= bus.reg2data;
        bus.ex_rd      <= bus.rd;
      end
      if (live & taken) begin
        bus.redirect_pc <= target;
        sq_cnt          <= 2'(FLUSH_SLOTS);
      end else if (accept & squashed) begin
        sq_cnt <= sq_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_nq_execute_stage.sv
// tb/tb_nq_execute_stage.sv - directed self-checking bench for nq_execute_stage.
module tb_nq_execute_stage;
  import nq_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  nq_execute_stage_if bus ();

  nq_execute_stage #(.FLUSH_SLOTS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                       input logic [1:0] sh, input logic [6:0] iv, input logic [2:0] d,
                       input logic [31:0] p, input logic j, input logic jrr, input logic bn,
                       input logic mr, input logic mw);
    bus.valid    = 1'b1;
    bus.reg1data = a;
    bus.reg2data = b;
    bus.ALU_func = f;
    bus.shamt    = sh;
    bus.iVal     = iv;
    bus.rd       = d;
    bus.pc       = p;
    bus.jmp      = j;
    bus.jr       = jrr;
    bus.bne      = bn;
    bus.memRead  = mr;
    bus.memWrite = mw;
  endtask

  task automatic idle();
    bus.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_stall = 1'b0;
    issue(16'h1234, 16'h1, ALU_ADD, OPB_REG, 7'd0, 3'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    tests++;
    if ({bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.redirect} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.redirect});
    end
    tests++;
    if ({bus.alu_result, bus.store_data, bus.redirect_pc, bus.ex_rd} !== 67'd0) begin
      fails++;
      $display("FAIL reset_data: got alu=%h sd=%h rpc=%h rd=%h expected all zero",
               bus.alu_result, bus.store_data, bus.redirect_pc, bus.ex_rd);
    end
    tests++;
    if (dut.sq_cnt !== 2'd0) begin
      fails++;
      $display("FAIL reset_sq: got %0d expected 0", dut.sq_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_alu();
    issue(16'h7FFF, 16'h0001, ALU_ADD, OPB_REG, 7'd0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.ex_valid, bus.ex_regWrite, bus.ex_rd, bus.alu_result} !== {1'b1, 1'b1, 3'd3, 16'h8000}) begin
      fails++;
      $display("FAIL add_ovf: got v=%b w=%b rd=%0d res=%h expected v=1 w=1 rd=3 res=8000",
               bus.ex_valid, bus.ex_regWrite, bus.ex_rd, bus.alu_result);
    end
    issue(16'h8000, 16'h0001, ALU_SLT, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'h0001) begin
      fails++;
      $display("FAIL slt_signed: got %h expected 0001", bus.alu_result);
    end
    issue(16'h0003, 16'h0005, ALU_SUB, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'hFFFE) begin
      fails++;
      $display("FAIL sub_wrap: got %h expected fffe", bus.alu_result);
    end
    issue(16'h8000, 16'h0004, ALU_SRL, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'h0800) begin
      fails++;
      $display("FAIL srl: got %h expected 0800", bus.alu_result);
    end
    issue(16'h0001, 16'h0013, ALU_SLL, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'h0008) begin
      fails++;
      $display("FAIL sll_low4: got %h expected 0008", bus.alu_result);
    end
    issue(16'h0005, 16'h0000, ALU_ADD, OPB_SEXT, 7'h7F, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'd4) begin
      fails++;
      $display("FAIL imm_sext: got %0d expected 4", bus.alu_result);
    end
    issue(16'h0005, 16'h0000, ALU_ADD, OPB_ZEXT, 7'h7F, 3'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if (bus.alu_result !== 16'd132) begin
      fails++;
      $display("FAIL imm_zext: got %0d expected 132", bus.alu_result);
    end
    issue(16'h0010, 16'hA5A5, ALU_XOR, OPB_SEXT, 7'd2, 3'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    tests++;
    if ({bus.alu_result, bus.store_data, bus.ex_memWrite, bus.ex_regWrite} !== {16'h0012, 16'hA5A5, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL store: got addr=%h sd=%h mw=%b w=%b expected addr=0012 sd=a5a5 mw=1 w=0",
               bus.alu_result, bus.store_data, bus.ex_memWrite, bus.ex_regWrite);
    end
    issue(16'h0005, 16'h0005, ALU_ADD, OPB_SEXT, 7'd3, 3'd0, 32'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, bus.ex_valid, bus.ex_regWrite} !== 3'b010) begin
      fails++;
      $display("FAIL bne_not_taken: got r/v/w=%b expected 010", {bus.redirect, bus.ex_valid, bus.ex_regWrite});
    end
    idle();
    step();
    tests++;
    if ({bus.ex_valid, bus.alu_result} !== {1'b0, 16'd8}) begin
      fails++;
      $display("FAIL idle_hold: got v=%b res=%h expected v=0 res=0008", bus.ex_valid, bus.alu_result);
    end
  endtask

  task automatic test_branch();
    issue(16'd3, 16'd4, ALU_ADD, OPB_REG, 7'h7E, 3'd1, 32'd100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, bus.redirect_pc, bus.ex_regWrite} !== {1'b1, 32'd99, 1'b0}) begin
      fails++;
      $display("FAIL bne_taken: got r=%b pc=%0d w=%b expected r=1 pc=99 w=0",
               bus.redirect, bus.redirect_pc, bus.ex_regWrite);
    end
    issue(16'd1, 16'd1, ALU_ADD, OPB_REG, 7'd0, 3'd2, 32'd101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.ex_valid, bus.redirect, bus.ex_regWrite, dut.sq_cnt} !== 5'b0) begin
      fails++;
      $display("FAIL squash_slot: got v=%b r=%b w=%b sq=%0d expected all 0",
               bus.ex_valid, bus.redirect, bus.ex_regWrite, dut.sq_cnt);
    end
    issue(16'd2, 16'd2, ALU_ADD, OPB_REG, 7'd0, 3'd2, 32'd99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.ex_valid, bus.alu_result} !== {1'b1, 16'd4}) begin
      fails++;
      $display("FAIL after_squash: got v=%b res=%0d expected v=1 res=4", bus.ex_valid, bus.alu_result);
    end
  endtask

  task automatic test_jump();
    issue(16'hBEEF, 16'd0, ALU_ADD, OPB_REG, 7'd0, 3'd0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'h0000BEEF}) begin
      fails++;
      $display("FAIL jr_target: got r=%b pc=%h expected r=1 pc=0000beef", bus.redirect, bus.redirect_pc);
    end
    issue(16'd1, 16'd2, ALU_ADD, OPB_REG, 7'd5, 3'd0, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, bus.ex_valid, bus.redirect_pc} !== {1'b0, 1'b0, 32'h0000BEEF}) begin
      fails++;
      $display("FAIL bne_in_squash: got r=%b v=%b pc=%h expected r=0 v=0 pc=0000beef",
               bus.redirect, bus.ex_valid, bus.redirect_pc);
    end
    issue(16'd0, 16'd0, ALU_ADD, OPB_REG, 7'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, bus.redirect_pc} !== {1'b1, 32'd0}) begin
      fails++;
      $display("FAIL jmp_wrap: got r=%b pc=%h expected r=1 pc=00000000", bus.redirect, bus.redirect_pc);
    end
    idle();
    step();
    tests++;
    if ({bus.redirect, bus.ex_valid, dut.sq_cnt} !== {1'b0, 1'b0, 2'd1}) begin
      fails++;
      $display("FAIL idle_no_dec: got r=%b v=%b sq=%0d expected r=0 v=0 sq=1",
               bus.redirect, bus.ex_valid, dut.sq_cnt);
    end
    issue(16'd1, 16'd1, ALU_ADD, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.ex_valid, dut.sq_cnt} !== 3'b0) begin
      fails++;
      $display("FAIL squash_after_idle: got v=%b sq=%0d expected v=0 sq=0", bus.ex_valid, dut.sq_cnt);
    end
  endtask

  task automatic test_stall();
    issue(16'd3, 16'd4, ALU_ADD, OPB_REG, 7'd1, 3'd6, 32'd200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    bus.mem_stall = 1'b1;
    issue(16'd9, 16'd9, ALU_ADD, OPB_REG, 7'd0, 3'd2, 32'd201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    tests++;
    if ({bus.redirect, bus.redirect_pc, bus.in_ready} !== {1'b1, 32'd202, 1'b0}) begin
      fails++;
      $display("FAIL stall_redirect_first: got r=%b pc=%0d rdy=%b expected r=1 pc=202 rdy=0",
               bus.redirect, bus.redirect_pc, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({bus.redirect, bus.in_ready, bus.ex_valid, bus.alu_result, bus.ex_rd, bus.redirect_pc, dut.sq_cnt}
          !== {1'b0, 1'b0, 1'b1, 16'd7, 3'd6, 32'd202, 2'd1}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got r=%b rdy=%b v=%b res=%0d rd=%0d pc=%0d sq=%0d expected r=0 rdy=0 v=1 res=7 rd=6 pc=202 sq=1",
                 i, bus.redirect, bus.in_ready, bus.ex_valid, bus.alu_result, bus.ex_rd,
                 bus.redirect_pc, dut.sq_cnt);
      end
    end
    bus.mem_stall = 1'b0;
    step();
    tests++;
    if ({bus.ex_valid, dut.sq_cnt, bus.alu_result} !== {1'b0, 2'd0, 16'd7}) begin
      fails++;
      $display("FAIL stall_release_squash: got v=%b sq=%0d res=%0d expected v=0 sq=0 res=7",
               bus.ex_valid, dut.sq_cnt, bus.alu_result);
    end
    issue(16'd1, 16'd1, ALU_ADD, OPB_REG, 7'd0, 3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.ex_valid, bus.alu_result} !== {1'b1, 16'd2}) begin
      fails++;
      $display("FAIL stall_release_live: got v=%b res=%0d expected v=1 res=2", bus.ex_valid, bus.alu_result);
    end
  endtask

  task automatic test_reset_mid_squash();
    issue(16'd3, 16'd4, ALU_ADD, OPB_REG, 7'd1, 3'd6, 32'd300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++;
    if ({bus.redirect, dut.sq_cnt} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL pre_reset_redirect: got r=%b sq=%0d expected r=1 sq=1", bus.redirect, dut.sq_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.redirect,
         bus.alu_result, bus.store_data, bus.redirect_pc, bus.ex_rd, dut.sq_cnt} !== 74'd0) begin
      fails++;
      $display("FAIL async_reset: got v=%b r=%b res=%h sd=%h pc=%h rd=%0d sq=%0d expected all 0",
               bus.ex_valid, bus.redirect, bus.alu_result, bus.store_data, bus.redirect_pc,
               bus.ex_rd, dut.sq_cnt);
    end
    issue(16'd2, 16'd3, ALU_ADD, OPB_REG, 7'd0, 3'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    tests++;
    if ({bus.ex_valid, bus.ex_regWrite, bus.alu_result, bus.ex_rd} !== {1'b1, 1'b1, 16'd5, 3'd5}) begin
      fails++;
      $display("FAIL post_reset_live: got v=%b w=%b res=%0d rd=%0d expected v=1 w=1 res=5 rd=5",
               bus.ex_valid, bus.ex_regWrite, bus.alu_result, bus.ex_rd);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid_squash();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nq_execute_stage.md
# nq_execute_stage

Execute stage of the NanoQuarter 16-bit pipeline, directly downstream of the decode/register-read stage. Registers the decoded operands and control, performs the ALU operation, resolves `bne`/`jmp`, and presents registered results to the memory stage. On a taken control transfer it issues a one-cycle redirect to the PC mux and squashes the wrong-path instructions already in flight.

## Interface

- `FLUSH_SLOTS`, default 1: number of accepted instructions discarded after a taken redirect (1..3).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid` in 1: decode presents an instruction.
- `reg1data`, `reg2data` in 16: source operands A and B.
- `ALU_func` in 3: operation code.
- `shamt` in 2: operand-B select: 00 `reg2data`, 01 sign-extended `iVal`, 10 zero-extended `iVal`, 11 reserved (treated as 00).
- `iVal` in 7: immediate.
- `rd` in 3: destination register.
- `pc` in 32: word address of this instruction.
- `jmp`, `jr`, `bne`, `memRead`, `memWrite` in 1: decoded control.
- `mem_stall` in 1: memory stage cannot accept.
- `in_ready` out 1: `~mem_stall`; an instruction is accepted on an edge where `valid & in_ready`.
- `ex_valid` out 1: registered result is a live instruction.
- `alu_result` out 16: ALU output or memory address.
- `store_data` out 16: `reg2data` forwarded for stores.
- `ex_rd` out 3, `ex_memRead` out 1, `ex_memWrite` out 1, `ex_regWrite` out 1.
- `redirect` out 1: one-cycle pulse, taken branch/jump.
- `redirect_pc` out 32: target, valid while `redirect` is high.

## Operation

- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL (logical), 7 SLT (signed, result 0/1).
- All arithmetic is 16-bit modulo; carries and overflow are discarded.
- Shift amount is B[3:0].
- For loads and stores, `alu_result` = A + B, which is the address.
- `ex_regWrite` = accepted & ~squashed & ~`memWrite` & ~`bne` & ~`jmp`.
- Branch: `bne` is taken when A != B (raw `reg2data`, independent of `shamt`). Target = `pc` + 1 + sext(`iVal`), 32-bit wrap.
- Jump: `jmp & jr` targets {16'b0, A}. `jmp & ~jr` targets `pc` + 1 + sext(`iVal`).
- A redirect is raised only by an accepted, non-squashed instruction.
- Squash counter `sq_cnt` (2 bits):
  - loaded with `FLUSH_SLOTS` when a redirect is raised;
  - each subsequent accepted `valid` instruction with `sq_cnt` != 0 is dropped (`ex_valid` = 0, no redirect, no write) and decrements the counter;
  - idle cycles (`valid` = 0) do not decrement.
- If `mem_stall` is high, all output registers hold their values, nothing is accepted, `sq_cnt` holds, and `redirect` is forced low after its first cycle.
- Not-accepted cycles with `mem_stall` low produce `ex_valid` = 0; data outputs hold.

## Timing

- Latency is 1: an instruction accepted at edge N drives `ex_*`, `alu_result`, `redirect`, and `redirect_pc` after edge N.
- `redirect` is high for exactly one cycle per taken transfer.
- A branch whose operands cause a redirect in the same cycle that `mem_stall` rises was accepted on the prior edge, so its redirect still completes that single cycle.
- Reset (async assert, any time, including mid-squash):
  - `ex_valid`, `ex_regWrite`, `ex_memRead`, `ex_memWrite`, and `redirect` are 0;
  - `alu_result`, `store_data`, and `redirect_pc` are 0;
  - `ex_rd` = 0 and `sq_cnt` = 0.
- The first edge after reset deassertion may accept an instruction.
- A branch arriving in a squashed slot is ignored entirely.

## Structure

- Shared package `nq_pkg`: ALU code constants (`ALU_ADD` through `ALU_SLT`), operand-select constants (`OPB_REG`, `OPB_SEXT`, `OPB_ZEXT`), and the default `FLUSH_SLOTS`.
- One combinational sub-module `nq_alu` (A, B, func → result). The top level holds the pipeline registers, branch resolution, and the squash counter.

## Test plan

- ADD with A = 16'h7FFF and reg B = 1 → `alu_result` 16'h8000 one cycle later, `ex_regWrite` = 1. SLT with A = 16'h8000 and B = 1 → 1.
- `shamt` = 01, `iVal` = 7'h7F, ADD with A = 5 → 4. `shamt` = 10 with the same values → 132.
- `bne` with A = 3, B = 4, `pc` = 100, `iVal` = 7'h7E → `redirect` pulse with `redirect_pc` = 99. The next accepted instruction has `ex_valid` = 0, and the one after it is live.
- `jmp & jr` with A = 16'hBEEF → `redirect_pc` = 32'h0000BEEF. A `bne` in the squashed slot gives no second redirect.
- `mem_stall` held for 3 cycles with `valid` high → `in_ready` = 0, outputs frozen, `sq_cnt` unchanged. Release → the instruction is accepted on the next edge.
- Assert `rst` low mid-squash (`sq_cnt` = 1) → all outputs 0 immediately. After release, the first valid instruction is live.
